// File: rtl/avalon_st_to_sdram_burst_writer_pkg.sv
// Shared definitions for the ST-to-SDRAM burst writer.
//   state_t          : controller states (IDLE / BURST)
//   CSR_*            : CSR word indices
//   INSTR_ADDR_*     : byte-address field of the 64-bit instruction word
//   CSR_DEFAULT_DATA : value returned for unmapped CSR indices
package avalon_st_sdram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [2:0] CSR_STATE     = 3'd0;
  localparam logic [2:0] CSR_DONE      = 3'd1;
  localparam logic [2:0] CSR_CHECKSUM  = 3'd2;
  localparam logic [2:0] CSR_DROP      = 3'd3;
  localparam logic [2:0] CSR_STATUS    = 3'd4;
  localparam logic [2:0] CSR_MAX_BURST = 3'd5;

  // Byte address lives in [63:32]; burst length in the low BURST_W bits.
  localparam int INSTR_ADDR_LSB = 32;
  localparam int INSTR_ADDR_W   = 32;

  localparam logic [31:0] CSR_DEFAULT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_st_to_sdram_burst_writer_byte_lane_swap.sv
// Combinational byte-lane reversal plus 32-bit word sum of the result.
//   data_in  : incoming beat
//   data_out : beat with byte k taken from byte WIDTH/8-1-k (or passed through when ENABLE=0)
//   word_sum : sum of the 32-bit words of data_out, modulo 2^32
module byte_lane_swap #(
  parameter int WIDTH  = 256,
  parameter bit ENABLE = 1'b1
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [31:0]      word_sum
);

  localparam int BYTES = WIDTH / 8;
  localparam int WORDS = WIDTH / 32;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    data_out = data_in;
    if (ENABLE) begin
      for (int k = 0; k < BYTES; k++) begin
        data_out[8*k +: 8] = data_in[8*(BYTES-1-k) +: 8];
      end
    end
  end

  always_comb begin
    word_sum = '0;
    for (int w = 0; w < WORDS; w++) begin
      word_sum = word_sum + data_out[32*w +: 32];
    end
  end

endmodule

// File: rtl/avalon_st_to_sdram_burst_writer.sv
// Moves a commanded number of beats from an Avalon-ST data stream into one
// Avalon-MM burst write, with optional byte-lane swap, and exposes bring-up
// counters and a running checksum over a small CSR port.
//   clock, reset         : single clock, synchronous active-high reset
//   st_instruction_*     : command stream ([63:32] byte address, low bits length)
//   st_valid/data/ready  : data beats
//   mm_*                 : Avalon-MM burst master
//   csr_*                : CSR slave, read data registered (1-cycle latency)
module avalon_st_to_sdram_burst_writer
  import avalon_st_sdram_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 27,
  parameter int BURST_W   = 8,
  parameter int MAX_BURST = 8,
  parameter int BYTE_SWAP = 1
) (
  input  logic                clock,
  input  logic                reset,
  output logic [ADDR_W-1:0]   mm_addr,
  output logic [DATA_W/8-1:0] mm_byteenable,
  output logic [BURST_W-1:0]  mm_burstcount,
  output logic                mm_write,
  output logic [DATA_W-1:0]   mm_writedata,
  input  logic                mm_waitrequest,
  input  logic                st_instruction_valid,
  output logic                st_instruction_ready,
  input  logic [63:0]         st_instruction_data,
  input  logic                st_valid,
  input  logic [DATA_W-1:0]   st_data,
  output logic                st_ready,
  input  logic [2:0]          csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  output logic [31:0]         csr_readdata
);

  // Byte address -> word address shift; assumes ADDR_SHIFT + ADDR_W <= 32.
  localparam int ADDR_SHIFT = $clog2(DATA_W / 8);
  localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(MAX_BURST);

  state_t state, next_state;

  logic [BURST_W-1:0] issued;
  logic [BURST_W-1:0] retired;
  logic [31:0]        done_count;
  logic [31:0]        drop_count;
  logic [31:0]        checksum;

  logic [BURST_W-1:0]      cmd_len;
  logic [INSTR_ADDR_W-1:0] cmd_addr;
  logic                    cmd_legal;
  logic                    beat_accept;
  logic                    beat_retire;
  logic                    last_retire;
  logic                    csr_clear;
  logic [DATA_W-1:0]       swapped_beat;
  logic [31:0]             beat_sum;
  logic [31:0]             csr_mux;

  assign cmd_len   = st_instruction_data[BURST_W-1:0];
  assign cmd_addr  = st_instruction_data[INSTR_ADDR_LSB +: INSTR_ADDR_W];
  assign cmd_legal = (cmd_len != '0) && (cmd_len <= MAX_LEN);

  assign beat_accept = st_valid && st_ready;
  assign beat_retire = mm_write && !mm_waitrequest;
  assign last_retire = beat_retire && ((retired + BURST_W'(1)) == mm_burstcount);
  assign csr_clear   = csr_write && (csr_address == CSR_DONE);

  // Write data is don't-care, address bits below the beat size are ignored,
  // and only the low BURST_W bits of the length field are meaningful.
  logic unused_bits;
  assign unused_bits = ^{csr_writedata, st_instruction_data[31:BURST_W],
                         cmd_addr[ADDR_SHIFT-1:0]};

  byte_lane_swap #(
    .WIDTH  (DATA_W),
    .ENABLE (BYTE_SWAP != 0)
  ) u_swap (
    .data_in  (st_data),
    .data_out (swapped_beat),
    .word_sum (beat_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state           = state;
    st_instruction_ready = 1'b0;
    st_ready             = 1'b0;
    case (state)
      ST_IDLE: begin
        st_instruction_ready = 1'b1;
        if (st_instruction_valid && cmd_legal) next_state = ST_BURST;
      end
      ST_BURST: begin
        // A new beat can load only when the output register is free or draining.
        st_ready = (!mm_write || !mm_waitrequest) && (issued < mm_burstcount);
        if (last_retire) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_mux = CSR_DEFAULT_DATA;
    case (csr_address)
      CSR_STATE:     csr_mux = 32'(state);
      CSR_DONE:      csr_mux = done_count;
      CSR_CHECKSUM:  csr_mux = checksum;
      CSR_DROP:      csr_mux = drop_count;
      CSR_STATUS:    csr_mux = {26'd0, mm_write, mm_waitrequest, st_instruction_valid,
                                st_instruction_ready, st_valid, st_ready};
      CSR_MAX_BURST: csr_mux = 32'(MAX_BURST);
      default:       csr_mux = CSR_DEFAULT_DATA;
    endcase
  end

  // NOTE: the wide writedata register is reset together with the rest so the
  // bus never shows stale data after reset; a storage array would not be.
  always_ff @(posedge clock) begin
    if (reset) begin
      mm_addr       <= '0;
      mm_byteenable <= '0;
      mm_burstcount <= '0;
      mm_write      <= 1'b0;
      mm_writedata  <= '0;
      issued        <= '0;
      retired       <= '0;
      done_count    <= '0;
      drop_count    <= '0;
      checksum      <= '0;
      csr_readdata  <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (st_instruction_valid) begin
          if (cmd_legal) begin
            mm_addr       <= cmd_addr[ADDR_SHIFT +: ADDR_W];
            mm_burstcount <= cmd_len;
            mm_byteenable <= '1;
            issued        <= '0;
            retired       <= '0;
          end else begin
            drop_count <= drop_count + 32'd1;
          end
        end
      end else begin
        // Under waitrequest, st_ready is low, so nothing here touches the
        // presented address, count, data or write strobe.
        if (beat_accept) begin
          mm_writedata <= swapped_beat;
          mm_write     <= 1'b1;
          issued       <= issued + BURST_W'(1);
          checksum     <= checksum + beat_sum;
        end else if (beat_retire) begin
          mm_write <= 1'b0;
        end
        if (beat_retire) begin
          retired <= retired + BURST_W'(1);
          if (last_retire) done_count <= done_count + 32'd1;
        end
      end

      // Placed after the increments so a coincident clear wins.
      if (csr_clear) begin
        done_count <= '0;
        drop_count <= '0;
        checksum   <= '0;
      end

      if (csr_read) csr_readdata <= csr_mux;
    end
  end

endmodule

// File: tb/tb_avalon_st_to_sdram_burst_writer.sv
module tb_avalon_st_to_sdram_burst_writer;

  localparam int DW = 256;

  logic            clock = 1'b0;
  logic            reset;
  logic [26:0]     mm_addr;
  logic [31:0]     mm_byteenable;
  logic [7:0]      mm_burstcount;
  logic            mm_write;
  logic [DW-1:0]   mm_writedata;
  logic            mm_waitrequest;
  logic            st_instruction_valid;
  logic            st_instruction_ready;
  logic [63:0]     st_instruction_data;
  logic            st_valid;
  logic [DW-1:0]   st_data;
  logic            st_ready;
  logic [2:0]      csr_address;
  logic            csr_read;
  logic            csr_write;
  logic [31:0]     csr_writedata;
  logic [31:0]     csr_readdata;

  avalon_st_to_sdram_burst_writer dut (
    .clock                (clock),
    .reset                (reset),
    .mm_addr              (mm_addr),
    .mm_byteenable        (mm_byteenable),
    .mm_burstcount        (mm_burstcount),
    .mm_write             (mm_write),
    .mm_writedata         (mm_writedata),
    .mm_waitrequest       (mm_waitrequest),
    .st_instruction_valid (st_instruction_valid),
    .st_instruction_ready (st_instruction_ready),
    .st_instruction_data  (st_instruction_data),
    .st_valid             (st_valid),
    .st_data              (st_data),
    .st_ready             (st_ready),
    .csr_address          (csr_address),
    .csr_read             (csr_read),
    .csr_write            (csr_write),
    .csr_writedata        (csr_writedata),
    .csr_readdata         (csr_readdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] baddr;
    logic [7:0]  len;
    int          vpct;        // valid probability in %, -1 = toggle 1,0,1,0
    int          wpct;        // random waitrequest probability in %
    int          stall_beat;  // beat index held 4 cycles under waitrequest, -1 = none
    bit          legal;
    logic [26:0] exp_addr;
    int          exp_cyc;     // cycles from command consumed to last retire, -1 = any
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_done   = 0;
  int unsigned m_drop   = 0;
  logic [31:0] m_sum    = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: byte k of the output is byte 31-k of the input.
  function automatic logic [DW-1:0] ref_swap(input logic [DW-1:0] d);
    logic [DW-1:0] s;
    s = {<<8{d}};
    return s;
  endfunction

  function automatic logic [31:0] ref_sum(input logic [DW-1:0] d);
    logic [31:0] s = '0;
    for (int w = 0; w < DW/32; w++) s += d[32*w +: 32];
    return s;
  endfunction

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    @(negedge clock);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    @(negedge clock);
    csr_write = 1'b0;
  endtask

  // Issue one command and, if legal, feed and track its whole burst.
  // Entered and left at a negedge with the DUT expected in IDLE.
  task automatic run_cmd(input vec_t v, input bit pattern);
    logic [DW-1:0] beats [16];
    int r, i, cyc, stall_left;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < DW/32; k++) beats[j][32*k +: 32] = $urandom;
    if (pattern)
      for (int k = 0; k < DW/8; k++) beats[0][8*k +: 8] = 8'(k);

    st_instruction_valid = 1'b1;
    st_instruction_data  = {v.baddr, 24'h0, v.len};
    st_valid             = 1'b1;
    st_data              = beats[0];
    mm_waitrequest       = 1'b0;
    #1;
    check({v.name, ".cmd_ready"}, st_instruction_ready, 1'b1);
    check({v.name, ".idle_no_data"}, st_ready, 1'b0);
    @(negedge clock);
    st_instruction_valid = 1'b0;
    st_valid             = 1'b0;

    if (!v.legal) begin
      m_drop++;
      check({v.name, ".drop_no_write"}, mm_write, 1'b0);
      check({v.name, ".drop_idle"}, st_instruction_ready, 1'b1);
      return;
    end

    r = 0; i = 0; cyc = 0; stall_left = 4;
    while (r < int'(v.len) && cyc < 300) begin
      st_valid = (i < int'(v.len)) &&
                 ((v.vpct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < v.vpct));
      st_data  = beats[i];
      if (v.stall_beat == r && mm_write && stall_left > 0) begin
        mm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mm_waitrequest = (v.stall_beat < 0) && ($urandom_range(99) < v.wpct);
      end
      #1;
      if (mm_write && mm_waitrequest) check({v.name, ".stall_ready"}, st_ready, 1'b0);
      if (mm_write && !mm_waitrequest) begin
        check($sformatf("%s.addr%0d", v.name, r), mm_addr, v.exp_addr);
        check($sformatf("%s.bc%0d", v.name, r), mm_burstcount, v.len);
        check($sformatf("%s.be%0d", v.name, r), mm_byteenable, 32'hFFFF_FFFF);
        check($sformatf("%s.data%0d", v.name, r), mm_writedata, ref_swap(beats[r]));
        r++;
      end
      if (st_valid && st_ready) i++;
      @(negedge clock);
      cyc++;
    end
    st_valid       = 1'b0;
    mm_waitrequest = 1'b0;
    check({v.name, ".retired"}, r, v.len);
    if (v.exp_cyc >= 0) check({v.name, ".cycles"}, cyc, v.exp_cyc);
    check({v.name, ".end_write_low"}, mm_write, 1'b0);
    check({v.name, ".end_idle"}, st_instruction_ready, 1'b1);
    m_done++;
    for (int j = 0; j < int'(v.len); j++) m_sum += ref_sum(ref_swap(beats[j]));
  endtask

  vec_t        vecs [8];
  vec_t        v;
  logic [31:0] rd;

  initial begin
    reset = 1'b1;
    mm_waitrequest = 1'b0;
    st_instruction_valid = 1'b0;
    st_instruction_data  = '0;
    st_valid = 1'b0;
    st_data  = '0;
    csr_address = '0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = '0;

    vecs[0] = '{"b2b8",     32'h0000_1000, 8'd8, 100,  0, -1, 1'b1, 27'h80,      9};
    vecs[1] = '{"stall3",   32'h0000_0040, 8'd3, 100,  0,  1, 1'b1, 27'h2,       8};
    vecs[2] = '{"toggle4",  32'h0000_3000, 8'd4,  -1,  0, -1, 1'b1, 27'h180,     8};
    vecs[3] = '{"len0",     32'h0000_5000, 8'd0, 100,  0, -1, 1'b0, 27'h0,      -1};
    vecs[4] = '{"len9",     32'h0000_6000, 8'd9, 100,  0, -1, 1'b0, 27'h0,      -1};
    vecs[5] = '{"unalign",  32'h0000_101F, 8'd2, 100,  0, -1, 1'b1, 27'h80,      3};
    vecs[6] = '{"top",      32'hFFFF_FFE0, 8'd8,  60, 40, -1, 1'b1, 27'h7FF_FFFF, -1};
    vecs[7] = '{"len1",     32'h1234_5678, 8'd1, 100,  0, -1, 1'b1, 27'h91_A2B3,  2};

    repeat (3) @(negedge clock);
    check("rst.mm_write", mm_write, 1'b0);
    check("rst.mm_addr", mm_addr, 27'h0);
    check("rst.mm_burstcount", mm_burstcount, 8'h0);
    check("rst.mm_byteenable", mm_byteenable, 32'h0);
    check("rst.mm_writedata", mm_writedata, '0);
    check("rst.csr_readdata", csr_readdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    csr_rd(3'd0, rd); check("csr.state_idle", rd, 32'd0);
    csr_rd(3'd5, rd); check("csr.max_burst", rd, 32'd8);
    csr_rd(3'd7, rd); check("csr.default", rd, 32'hDEAD_BEEF);
    csr_rd(3'd1, rd); check("csr.done_rst", rd, 32'd0);

    // Data offered in IDLE is not taken; status shows ins_ready and st_valid.
    st_valid = 1'b1;
    st_data  = {8{32'hA5A5_5A5A}};
    #1;
    check("idle.st_ready", st_ready, 1'b0);
    csr_rd(3'd4, rd); check("csr.status_idle", rd, 32'h6);
    st_valid = 1'b0;

    for (int n = 0; n < 8; n++) run_cmd(vecs[n], 1'b0);
    csr_rd(3'd1, rd); check("tbl.done", rd, m_done);
    csr_rd(3'd3, rd); check("tbl.drop", rd, m_drop);
    csr_rd(3'd2, rd); check("tbl.checksum", rd, m_sum);

    // Counting-byte beat: swapped byte 0 must be 0x1F, then clear counters.
    v = '{"pattern", 32'h0000_0000, 8'd1, 100, 0, -1, 1'b1, 27'h0, 2};
    run_cmd(v, 1'b1);
    check("pat.byte0", mm_writedata[7:0], 8'h1F);
    check("pat.byte31", mm_writedata[255:248], 8'h00);
    csr_rd(3'd2, rd); check("pat.checksum", rd, m_sum);
    csr_wr(3'd1, 32'h0);
    m_done = 0; m_drop = 0; m_sum = '0;
    csr_rd(3'd1, rd); check("clr.done", rd, 32'd0);
    csr_rd(3'd2, rd); check("clr.checksum", rd, 32'd0);
    csr_rd(3'd3, rd); check("clr.drop", rd, 32'd0);

    // Reset after two beats of an 8-beat burst abandons it.
    st_instruction_valid = 1'b1;
    st_instruction_data  = {32'h0000_2000, 24'h0, 8'd8};
    @(negedge clock);
    st_instruction_valid = 1'b0;
    st_valid = 1'b1;
    st_data  = {8{32'h1111_1111}};
    @(negedge clock);
    st_data  = {8{32'h2222_2222}};
    @(negedge clock);
    check("mid.write_high", mm_write, 1'b1);
    st_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    check("mid.write_low", mm_write, 1'b0);
    check("mid.idle", st_instruction_ready, 1'b1);
    check("mid.bc_zero", mm_burstcount, 8'h0);
    reset = 1'b0;
    m_done = 0; m_drop = 0; m_sum = '0;
    @(negedge clock);
    csr_rd(3'd0, rd); check("mid.state", rd, 32'd0);
    v = '{"fresh", 32'h0000_2000, 8'd8, 100, 0, -1, 1'b1, 27'h100, 9};
    run_cmd(v, 1'b0);

    // Randomised commands against the reference model.
    for (int n = 0; n < 25; n++) begin
      v.name       = $sformatf("rnd%0d", n);
      v.baddr      = $urandom;
      v.len        = 8'($urandom_range(0, 10));
      v.vpct       = $urandom_range(30, 100);
      v.wpct       = $urandom_range(0, 60);
      v.stall_beat = -1;
      v.legal      = (v.len >= 1) && (v.len <= 8);
      v.exp_addr   = 27'(v.baddr / 32);
      v.exp_cyc    = -1;
      run_cmd(v, 1'b0);
    end
    csr_rd(3'd1, rd); check("fin.done", rd, m_done);
    csr_rd(3'd2, rd); check("fin.checksum", rd, m_sum);
    csr_rd(3'd3, rd); check("fin.drop", rd, m_drop);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
